// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined IEEE-754 multiplier: exponent constants as
// functions of the exponent width, canonical-NaN fields, class codes and the S2 payload.
package fp_pkg;

    typedef enum logic [2:0] {
        FP_NAN,
        FP_INF,
        FP_ZERO,
        FP_DNORM,
        FP_NORM
    } fp_class_e;

    // Special-case decision carried from the multiply stage to the pack stage
    typedef struct packed {
        logic      sign;
        logic      spc;
        fp_class_e cls;
    } fp_spc_t;

    // Canonical quiet NaN: positive sign, all-ones exponent, only the mantissa MSB set
    localparam logic FP_QNAN_SIGN  = 1'b0;
    localparam logic FP_QNAN_QUIET = 1'b1;

    function automatic int fp_bias(input int n_exp);
        return (1 << (n_exp - 1)) - 1;
    endfunction

    function automatic int fp_emin(input int n_exp);
        return 1 - fp_bias(n_exp);
    endfunction

    function automatic int fp_emax(input int n_exp);
        return fp_bias(n_exp);
    endfunction

    function automatic fp_class_e fp_classify(input logic exp_ones, input logic exp_zero,
                                              input logic man_zero);
        if (exp_ones)
            return man_zero ? FP_INF : FP_NAN;
        if (exp_zero)
            return man_zero ? FP_ZERO : FP_DNORM;
        return FP_NORM;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; an all-zero input reports W.
module fp_lzc #(
    parameter int W  = 24,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  x,
    output logic [CW-1:0] cnt
);

    // The highest set bit is visited last, so it decides the count
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (x[i])
                cnt = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754 multiplier with denormal support, valid/ready flow control and a tag.
// Define FP_MUL_PIPE_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int N_EXP = 11,
    parameter int N_MAN = 52,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_EXP+N_MAN:0]   a,
    input  logic [N_EXP+N_MAN:0]   b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_EXP+N_MAN:0]   p,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   nan,
    output logic                   inf,
    output logic                   zero,
    output logic                   dnorm,
    output logic                   norm,
    output logic                   ovf,
    output logic                   unf,
    output logic                   inexact
);

    localparam int W   = N_EXP + N_MAN + 1;
    localparam int M   = N_MAN + 1;
    localparam int EW  = N_EXP + 2;
    localparam int LZW = $clog2(M + 1);
    localparam int SHW = $clog2(M + 2);

    localparam logic signed [EW-1:0] BIAS_S = EW'(fp_bias(N_EXP));
    localparam logic signed [EW-1:0] EMIN_S = EW'(fp_emin(N_EXP));
    localparam logic signed [EW-1:0] EMAX_S = EW'(fp_emax(N_EXP));
    localparam logic signed [EW-1:0] SH_MAX = EW'(M + 1);
    localparam logic signed [EW-1:0] ONE_S  = EW'(1);
    localparam logic [W-1:0] QNAN = {FP_QNAN_SIGN, {N_EXP{1'b1}}, FP_QNAN_QUIET, {(N_MAN-1){1'b0}}};

`ifdef FP_MUL_PIPE_RNE_EN
    localparam logic RNE_EN = 1'b1;
`else
    localparam logic RNE_EN = 1'b0;
`endif

    function automatic logic round_inc(input logic lsb, input logic guard, input logic sticky);
        return RNE_EN & guard & (sticky | lsb);
    endfunction

    function automatic logic [SHW-1:0] denorm_shift(input logic signed [EW-1:0] e);
        logic signed [EW-1:0] d;
        d = EMIN_S - e;
        if (d > SH_MAX)
            return SHW'(M + 1);
        return SHW'(d);
    endfunction

    function automatic logic [4:0] cls_onehot(input fp_class_e c);
        case (c)
            FP_NAN:   return 5'b10000;
            FP_INF:   return 5'b01000;
            FP_ZERO:  return 5'b00100;
            FP_DNORM: return 5'b00010;
            default:  return 5'b00001;
        endcase
    endfunction

    logic vld_p0, vld_p1, vld_p2;
    logic en;

    // The whole pipe freezes while the output is held, so bubbles are preserved
    assign en        = !(vld_p2 && !out_ready);
    assign in_ready  = en;
    assign out_valid = vld_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (en) begin
            vld_p0 <= in_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // ---- S1: unpack, classify, normalise denormal inputs ----
    logic [W-1:0]           op     [2];
    logic [M-1:0]           sig_s1 [2];
    logic signed [EW-1:0]   exp_s1 [2];
    fp_class_e              cls_s1 [2];

    assign op[0] = a;
    assign op[1] = b;

    for (genvar i = 0; i < 2; i++) begin : g_unpack
        logic [N_EXP-1:0] e_fld;
        logic [N_MAN-1:0] m_fld;
        logic [LZW-1:0]   lz;

        assign e_fld = op[i][W-2:N_MAN];
        assign m_fld = op[i][N_MAN-1:0];

        fp_lzc #(.W(M), .CW(LZW)) u_lzc (
            .x   ({1'b0, m_fld}),
            .cnt (lz)
        );

        assign cls_s1[i] = fp_classify(&e_fld, ~|e_fld, ~|m_fld);
        assign sig_s1[i] = (e_fld == '0) ? ({1'b0, m_fld} << lz) : {1'b1, m_fld};
        assign exp_s1[i] = (e_fld == '0) ? EMIN_S - signed'(EW'(lz))
                                         : signed'(EW'(e_fld)) - BIAS_S;
    end

    logic                 sign_p0;
    logic [M-1:0]         sig_p0 [2];
    logic signed [EW-1:0] exp_p0 [2];
    fp_class_e            cls_p0 [2];
    logic [TAG_W-1:0]     tag_p0;

    always_ff @(posedge clk) begin
        if (en) begin
            sign_p0 <= op[0][W-1] ^ op[1][W-1];
            sig_p0  <= sig_s1;
            exp_p0  <= exp_s1;
            cls_p0  <= cls_s1;
            tag_p0  <= in_tag;
        end
    end

    // ---- S2: significand multiply, exponent sum, special-case select ----
    logic [2*M-1:0]       prod_s2;
    logic signed [EW-1:0] exp_s2;
    fp_spc_t              spc_s2;
    logic                 any_nan, any_inf, any_zero;

    always_comb begin
        prod_s2    = {{M{1'b0}}, sig_p0[0]} * {{M{1'b0}}, sig_p0[1]};
        exp_s2     = exp_p0[0] + exp_p0[1];
        any_nan    = (cls_p0[0] == FP_NAN)  || (cls_p0[1] == FP_NAN);
        any_inf    = (cls_p0[0] == FP_INF)  || (cls_p0[1] == FP_INF);
        any_zero   = (cls_p0[0] == FP_ZERO) || (cls_p0[1] == FP_ZERO);
        spc_s2.sign = sign_p0;
        spc_s2.spc  = 1'b1;
        spc_s2.cls  = FP_NAN;
        if (any_nan || (any_inf && any_zero))
            spc_s2.cls = FP_NAN;
        else if (any_inf)
            spc_s2.cls = FP_INF;
        else if (any_zero)
            spc_s2.cls = FP_ZERO;
        else begin
            spc_s2.spc = 1'b0;
            spc_s2.cls = FP_NORM;
        end
    end

    logic [2*M-1:0]       prod_p1;
    logic signed [EW-1:0] exp_p1;
    fp_spc_t              spc_p1;
    logic [TAG_W-1:0]     tag_p1;

    always_ff @(posedge clk) begin
        if (en) begin
            prod_p1 <= prod_s2;
            exp_p1  <= exp_s2;
            spc_p1  <= spc_s2;
            tag_p1  <= tag_p0;
        end
    end

    // ---- S3: normalise, denormalise, round, pack, flags ----
    logic [M-1:0]           sig3, sig4;
    logic                   g3, s3, g4, s4, lost, inc, tiny, ovf_pre;
    logic signed [EW-1:0]   e3;
    logic [SHW-1:0]         sh;
    logic [M:0]             v, vsh;
    logic [N_EXP-1:0]       be_m1;
    logic [W-2:0]           mag;
    logic [W-1:0]           p_s3;
    fp_class_e              cls_s3;
    logic                   ovf_s3, unf_s3, inx_s3;

    always_comb begin
        if (prod_p1[2*M-1]) begin
            sig3 = prod_p1[2*M-1 -: M];
            g3   = prod_p1[M-1];
            s3   = |prod_p1[M-2:0];
            e3   = exp_p1 + ONE_S;
        end else begin
            sig3 = prod_p1[2*M-2 -: M];
            g3   = prod_p1[M-2];
            s3   = |prod_p1[M-3:0];
            e3   = exp_p1;
        end
        tiny    = (e3 < EMIN_S);
        ovf_pre = (e3 > EMAX_S);
        sh      = tiny ? denorm_shift(e3) : '0;
        v       = {sig3, g3};
        vsh     = v >> sh;
        lost    = |(v & ~({(M+1){1'b1}} << sh));
        sig4    = vsh[M:1];
        g4      = vsh[0];
        s4      = s3 | lost;
        inc     = round_inc(sig4[0], g4, s4);
        // Hidden bit adds into the exponent field, so a rounding carry or a
        // denormal that rounds up to the hidden position lands in the right field
        be_m1   = tiny ? '0 : N_EXP'(e3 + BIAS_S - ONE_S);
        mag     = {be_m1, {N_MAN{1'b0}}} + (W-1)'(sig4) + (W-1)'(inc);

        p_s3   = '0;
        cls_s3 = FP_ZERO;
        ovf_s3 = 1'b0;
        unf_s3 = 1'b0;
        inx_s3 = 1'b0;
        if (spc_p1.spc) begin
            cls_s3 = spc_p1.cls;
            case (spc_p1.cls)
                FP_NAN:  p_s3 = QNAN;
                FP_INF:  p_s3 = {spc_p1.sign, {N_EXP{1'b1}}, {N_MAN{1'b0}}};
                default: p_s3 = {spc_p1.sign, {(W-1){1'b0}}};
            endcase
        end else if (ovf_pre || (&mag[W-2:N_MAN])) begin
            p_s3   = {spc_p1.sign, {N_EXP{1'b1}}, {N_MAN{1'b0}}};
            cls_s3 = FP_INF;
            ovf_s3 = 1'b1;
            inx_s3 = 1'b1;
        end else begin
            p_s3   = {spc_p1.sign, mag};
            inx_s3 = g4 | s4;
            unf_s3 = tiny & (g4 | s4);
            if (mag[W-2:N_MAN] != '0)
                cls_s3 = FP_NORM;
            else if (mag != '0)
                cls_s3 = FP_DNORM;
            else
                cls_s3 = FP_ZERO;
        end
    end

    logic [W-1:0]     p_p2;
    logic [TAG_W-1:0] tag_p2;
    logic [4:0]       cls_p2;
    logic             ovf_p2, unf_p2, inx_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_p2   <= '0;
            tag_p2 <= '0;
            cls_p2 <= '0;
            ovf_p2 <= 1'b0;
            unf_p2 <= 1'b0;
            inx_p2 <= 1'b0;
        end else if (en && vld_p1) begin
            p_p2   <= p_s3;
            tag_p2 <= tag_p1;
            cls_p2 <= cls_onehot(cls_s3);
            ovf_p2 <= ovf_s3;
            unf_p2 <= unf_s3;
            inx_p2 <= inx_s3;
        end
    end

    assign p       = p_p2;
    assign out_tag = tag_p2;
    assign {nan, inf, zero, dnorm, norm} = cls_p2;
    assign ovf     = ovf_p2;
    assign unf     = unf_p2;
    assign inexact = inx_p2;

endmodule
